// File: rtl/rv32_dec_pkg.sv
// Shared RV32 decode definitions: opcodes, select enums and the opcode decoder.
package rv32_dec_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;

  typedef struct packed {
    imm_sel_e  imm_sel;
    wb_sel_e   wb_sel;
    alu_ctrl_e alu;
    logic      op_a_pc;    // operand A = PC instead of rs1
    logic      op_b_imm;   // operand B = immediate instead of rs2
    logic      reg_write;
    logic      load;
    logic      store;
    logic      jump;
    logic      branch;
    logic      rs2_used;
    logic      illegal;
  } ctrl_t;

  // Arithmetic op from funct3; instr[30] selects SUB only for register ops, SRA for both.
  function automatic alu_ctrl_e alu_op(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'b000:  alu_op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  // Unrecognised opcodes come back with every side-effect flag clear and illegal set.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[6:0])
      OPC_LUI: begin
        c.imm_sel = IMM_U; c.alu = ALU_PASSB; c.op_b_imm = 1'b1; c.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        c.imm_sel = IMM_U; c.op_a_pc = 1'b1; c.op_b_imm = 1'b1; c.reg_write = 1'b1;
      end
      OPC_JAL: begin
        c.imm_sel = IMM_J; c.op_a_pc = 1'b1; c.op_b_imm = 1'b1; c.wb_sel = WB_PC4;
        c.reg_write = 1'b1; c.jump = 1'b1;
      end
      OPC_JALR: begin
        c.imm_sel = IMM_I; c.op_b_imm = 1'b1; c.wb_sel = WB_PC4;
        c.reg_write = 1'b1; c.jump = 1'b1;
      end
      OPC_BRANCH: begin
        c.imm_sel = IMM_B; c.op_a_pc = 1'b1; c.op_b_imm = 1'b1;
        c.branch = 1'b1; c.rs2_used = 1'b1;
      end
      OPC_LOAD: begin
        c.imm_sel = IMM_I; c.op_b_imm = 1'b1; c.wb_sel = WB_MEM;
        c.reg_write = 1'b1; c.load = 1'b1;
      end
      OPC_STORE: begin
        c.imm_sel = IMM_S; c.op_b_imm = 1'b1; c.store = 1'b1; c.rs2_used = 1'b1;
      end
      OPC_OPIMM: begin
        c.imm_sel = IMM_I; c.op_b_imm = 1'b1; c.reg_write = 1'b1;
        c.alu = alu_op(instr[14:12], instr[30], 1'b0);
      end
      OPC_OP: begin
        c.reg_write = 1'b1; c.rs2_used = 1'b1;
        c.alu = alu_op(instr[14:12], instr[30], 1'b1);
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Two-read one-write register file with x0 hardwired to zero and optional write-through.
module decode_regfile
  import rv32_dec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] mem [0:(1<<REG_AW)-1];

  // Storage: cleared on reset, x0 never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << REG_AW); i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports: x0 reads zero; same-cycle write data forwarded when enabled.
  always_comb begin
    rdata1 = (ra1 == '0) ? '0 : mem[ra1];
    rdata2 = (ra2 == '0) ? '0 : mem[ra2];
    if (BYPASS_EN != 0 && we && waddr == ra1 && ra1 != '0) rdata1 = wdata;
    if (BYPASS_EN != 0 && we && waddr == ra2 && ra2 != '0) rdata2 = wdata;
  end

endmodule

// File: rtl/decode_stage_hs.sv
// RV32 ID stage and ID/EX register with valid/ready handshake, flush and load-use interlock.
module decode_stage_hs
  import rv32_dec_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_AW         = 5,
  parameter int BYPASS_EN      = 1,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc4_d,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   rd_e1,
  output logic [XLEN-1:0]   rd_e2,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc4_e,
  output logic [REG_AW-1:0] rs_e1,
  output logic [REG_AW-1:0] rs_e2,
  output logic [REG_AW-1:0] rd_e,
  output logic [3:0]        alu_ctrl_e,
  output logic              op_a_sel_e,
  output logic              op_b_sel_e,
  output logic [1:0]        write_back_e,
  output logic              reg_write_e,
  output logic              load_e,
  output logic              store_e,
  output logic              jump_e,
  output logic              branch_result_e,
  output logic              illegal_e
);

  // ---- stage p0: decode, register read, immediate, branch compare ----
  ctrl_t                    ctrl_p0;
  logic [REG_AW-1:0]        rs1_p0, rs2_p0, rd_p0;
  logic [XLEN-1:0]          op1_p0, op2_p0, imm_p0;
  logic signed [XLEN-1:0]   op1_s_p0, op2_s_p0;
  logic                     rs2_hi_p0, illegal_p0, br_p0;
  logic                     hazard, accept;

  assign ctrl_p0    = decode(instr);
  assign rs1_p0     = instr[15 +: REG_AW];
  assign rs2_p0     = instr[20 +: REG_AW];
  assign rd_p0      = instr[7 +: REG_AW];
  // RV32E: a register-form rs2 naming x16..x31 cannot be honoured.
  assign rs2_hi_p0  = (instr[24:20] >> REG_AW) != 5'd0;
  assign illegal_p0 = ctrl_p0.illegal | (ctrl_p0.rs2_used & rs2_hi_p0);

  decode_regfile #(
    .XLEN     (XLEN),
    .REG_AW   (REG_AW),
    .BYPASS_EN(BYPASS_EN)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .ra1   (rs1_p0),
    .ra2   (rs2_p0),
    .rdata1(op1_p0),
    .rdata2(op2_p0),
    .we    (wb_en),
    .waddr (wb_addr),
    .wdata (wb_data)
  );

  // Immediate builder: every format sign-extended from instr[31].
  always_comb begin
    case (ctrl_p0.imm_sel)
      IMM_I:   imm_p0 = XLEN'($signed(instr[31:20]));
      IMM_S:   imm_p0 = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:   imm_p0 = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_J:   imm_p0 = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_U:   imm_p0 = XLEN'($signed({instr[31:12], 12'b0}));
      default: imm_p0 = '0;
    endcase
  end

  assign op1_s_p0 = op1_p0;
  assign op2_s_p0 = op2_p0;

  // Branch condition on the (write-through) register operands.
  always_comb begin
    br_p0 = 1'b0;
    if (ctrl_p0.branch && !illegal_p0) begin
      case (instr[14:12])
        3'b000:  br_p0 = (op1_p0 == op2_p0);
        3'b001:  br_p0 = (op1_p0 != op2_p0);
        3'b100:  br_p0 = (op1_s_p0 <  op2_s_p0);
        3'b101:  br_p0 = (op1_s_p0 >= op2_s_p0);
        3'b110:  br_p0 = (op1_p0 <  op2_p0);
        3'b111:  br_p0 = (op1_p0 >= op2_p0);
        default: br_p0 = 1'b0;
      endcase
    end
  end

  // Load in EX whose result the instruction in ID needs: hold ID, let a bubble through.
  assign hazard   = (LOAD_USE_STALL != 0) && out_valid && load_e && (rd_e != '0) &&
                    ((rd_e == rs1_p0) || ((rd_e == rs2_p0) && ctrl_p0.rs2_used));
  // Flush always drains ID; the offered instruction is swallowed.
  assign in_ready = flush || (!hazard && (!out_valid || out_ready));
  assign accept   = in_valid && in_ready && !flush;

  // ---- stage p1: ID/EX register ----
  logic vld_p1, rw_p1, ld_p1, st_p1, jp_p1, br_p1, ill_p1;

  // Valid bit: flush clears, accept sets, consumption without refill leaves a bubble.
  always_ff @(posedge clk) begin
    if (rst)            vld_p1 <= 1'b0;
    else if (flush)     vld_p1 <= 1'b0;
    else if (accept)    vld_p1 <= 1'b1;
    else if (out_ready) vld_p1 <= 1'b0;
  end

  // Payload: captured only on an accepted instruction, otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_e1 <= '0; rd_e2 <= '0; imm_e <= '0; pc_e <= '0; pc4_e <= '0;
      rs_e1 <= '0; rs_e2 <= '0; rd_e <= '0;
      alu_ctrl_e <= '0; op_a_sel_e <= 1'b0; op_b_sel_e <= 1'b0; write_back_e <= '0;
      rw_p1 <= 1'b0; ld_p1 <= 1'b0; st_p1 <= 1'b0; jp_p1 <= 1'b0; br_p1 <= 1'b0; ill_p1 <= 1'b0;
    end else if (accept) begin
      rd_e1 <= op1_p0; rd_e2 <= op2_p0; imm_e <= imm_p0; pc_e <= pc_d; pc4_e <= pc4_d;
      rs_e1 <= rs1_p0; rs_e2 <= rs2_p0; rd_e <= rd_p0;
      alu_ctrl_e   <= ctrl_p0.alu;
      op_a_sel_e   <= ctrl_p0.op_a_pc;
      op_b_sel_e   <= ctrl_p0.op_b_imm;
      write_back_e <= ctrl_p0.wb_sel;
      rw_p1  <= ctrl_p0.reg_write & ~illegal_p0;
      ld_p1  <= ctrl_p0.load      & ~illegal_p0;
      st_p1  <= ctrl_p0.store     & ~illegal_p0;
      jp_p1  <= ctrl_p0.jump      & ~illegal_p0;
      br_p1  <= br_p0;
      ill_p1 <= illegal_p0;
    end
  end

  assign out_valid       = vld_p1;
  assign reg_write_e     = vld_p1 & rw_p1;
  assign load_e          = vld_p1 & ld_p1;
  assign store_e         = vld_p1 & st_p1;
  assign jump_e          = vld_p1 & jp_p1;
  assign branch_result_e = vld_p1 & br_p1;
  assign illegal_e       = vld_p1 & ill_p1;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Bench for decode_stage_hs: directed scenarios plus randomized traffic against a transaction model.
module tb_decode_stage_hs;
  import rv32_dec_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [31:0] instr, pc_d, pc4_d, wb_data;
  logic [4:0]  wb_addr;
  logic [31:0] rd_e1, rd_e2, imm_e, pc_e, pc4_e;
  logic [4:0]  rs_e1, rs_e2, rd_e;
  logic [3:0]  alu_ctrl;
  logic        op_a_sel_e, op_b_sel_e;
  logic [1:0]  write_back_e;
  logic        reg_write_e, load_e, store_e, jump_e, branch_result_e, illegal_e;

  decode_stage_hs #(.XLEN(32), .REG_AW(5), .BYPASS_EN(1), .LOAD_USE_STALL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .pc_d(pc_d), .pc4_d(pc4_d), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .rd_e1(rd_e1), .rd_e2(rd_e2), .imm_e(imm_e), .pc_e(pc_e), .pc4_e(pc4_e),
    .rs_e1(rs_e1), .rs_e2(rs_e2), .rd_e(rd_e), .alu_ctrl_e(alu_ctrl),
    .op_a_sel_e(op_a_sel_e), .op_b_sel_e(op_b_sel_e), .write_back_e(write_back_e),
    .reg_write_e(reg_write_e), .load_e(load_e), .store_e(store_e), .jump_e(jump_e),
    .branch_result_e(branch_result_e), .illegal_e(illegal_e)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---- reference model: architectural registers plus the one instruction EX should see ----
  logic [31:0] mreg [32];
  logic        m_vld;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_alu;
  logic        m_asel, m_bsel, m_rw, m_ld, m_st, m_jp, m_br, m_ill;
  logic [1:0]  m_wb;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    m_vld = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_pc4 = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_alu = 0; m_asel = 0; m_bsel = 0; m_wb = 0;
    m_rw = 0; m_ld = 0; m_st = 0; m_jp = 0; m_br = 0; m_ill = 0;
  endtask

  // Sign-extend the low 'bits' of v, arithmetically.
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    if (v[bits-1]) return v - (32'd1 << bits);
    return v;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'd0: return (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  task automatic ref_decode(input logic [31:0] ins, output logic [31:0] imm, output logic [3:0] alu,
                            output logic asel, output logic bsel, output logic [1:0] wb,
                            output logic rw, output logic ld, output logic st, output logic jp,
                            output logic isbr, output logic ill, output logic use2);
    imm = 0; alu = ALU_ADD; asel = 0; bsel = 0; wb = WB_ALU;
    rw = 0; ld = 0; st = 0; jp = 0; isbr = 0; ill = 0; use2 = 0;
    case (ins[6:0])
      7'h37: begin imm = ins & 32'hFFFFF000; alu = ALU_PASSB; bsel = 1; rw = 1; end
      7'h17: begin imm = ins & 32'hFFFFF000; asel = 1; bsel = 1; rw = 1; end
      7'h6F: begin
        imm = sx((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
                 (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
        asel = 1; bsel = 1; wb = WB_PC4; rw = 1; jp = 1;
      end
      7'h67: begin imm = sx(ins >> 20, 12); bsel = 1; wb = WB_PC4; rw = 1; jp = 1; end
      7'h63: begin
        imm = sx((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                 (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
        asel = 1; bsel = 1; isbr = 1; use2 = 1;
      end
      7'h03: begin imm = sx(ins >> 20, 12); bsel = 1; wb = WB_MEM; rw = 1; ld = 1; end
      7'h23: begin imm = sx(((ins >> 25) << 5) | ((ins >> 7) & 31), 12); bsel = 1; st = 1; use2 = 1; end
      7'h13: begin imm = sx(ins >> 20, 12); bsel = 1; rw = 1; alu = ref_alu(ins[14:12], ins[30], 0); end
      7'h33: begin rw = 1; use2 = 1; alu = ref_alu(ins[14:12], ins[30], 1); end
      default: ill = 1;
    endcase
  endtask

  function automatic logic ref_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) <  int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rdop(input logic [4:0] r);
    if (r == 0) return 0;
    if (wb_en && wb_addr == r) return wb_data;
    return mreg[r];
  endfunction

  // One clock: compare DUT against the model mid-cycle, then advance the model across the edge.
  task automatic step();
    logic [31:0] imm, a, b;
    logic [3:0]  alu;
    logic [1:0]  wb;
    logic        asel, bsel, rw, ld, st, jp, isbr, ill, use2, hz, rdy, take;
    logic [4:0]  r1, r2;
    @(negedge clk);
    chk("out_valid", out_valid, m_vld);
    chk("reg_write_e", reg_write_e, m_vld & m_rw);
    chk("load_e", load_e, m_vld & m_ld);
    chk("store_e", store_e, m_vld & m_st);
    chk("jump_e", jump_e, m_vld & m_jp);
    chk("branch_result_e", branch_result_e, m_vld & m_br);
    chk("illegal_e", illegal_e, m_vld & m_ill);
    if (m_vld) begin
      chk("rd_e1", rd_e1, m_rd1);
      chk("rd_e2", rd_e2, m_rd2);
      chk("pc_e", pc_e, m_pc);
      chk("pc4_e", pc4_e, m_pc4);
      chk("rs_e1", rs_e1, m_rs1);
      chk("rs_e2", rs_e2, m_rs2);
      chk("rd_e", rd_e, m_rd);
      if (!m_ill) begin
        chk("imm_e", imm_e, m_imm);
        chk("alu_ctrl_e", alu_ctrl, m_alu);
        chk("op_a_sel_e", op_a_sel_e, m_asel);
        chk("op_b_sel_e", op_b_sel_e, m_bsel);
        chk("write_back_e", write_back_e, m_wb);
      end
    end
    ref_decode(instr, imm, alu, asel, bsel, wb, rw, ld, st, jp, isbr, ill, use2);
    r1 = instr[19:15];
    r2 = instr[24:20];
    hz   = m_vld & m_ld & (m_rd != 0) & ((m_rd == r1) | ((m_rd == r2) & use2));
    rdy  = flush | (!hz & (!m_vld | out_ready));
    if (!rst) chk("in_ready", in_ready, rdy);
    take = in_valid & rdy & !flush;
    a = rdop(r1);
    b = rdop(r2);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (flush) m_vld = 0;
      else if (take) begin
        m_vld = 1; m_rd1 = a; m_rd2 = b; m_imm = imm; m_pc = pc_d; m_pc4 = pc4_d;
        m_rs1 = r1; m_rs2 = r2; m_rd = instr[11:7]; m_alu = alu; m_asel = asel; m_bsel = bsel;
        m_wb = wb; m_rw = rw; m_ld = ld; m_st = st; m_jp = jp; m_ill = ill;
        m_br = isbr & ref_branch(instr[14:12], a, b);
      end else if (out_ready) m_vld = 0;
      if (wb_en && wb_addr != 0) mreg[wb_addr] = wb_data;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    r   = $urandom;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = r[14:12];
    case ($urandom_range(0, 11))
      0:       return {1'b0, r[30], 5'd0, rs2, rs1, f3, rd, 7'h33};
      1:       return {r[31:20], rs1, f3, rd, 7'h13};
      2, 10, 11: return {r[31:20], rs1, 3'b010, rd, 7'h03};
      3:       return {r[31:25], rs2, rs1, 3'b010, r[11:7], 7'h23};
      4:       return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
      5:       return {r[31:12], rd, 7'h6F};
      6:       return {r[31:20], rs1, 3'b000, rd, 7'h67};
      7:       return {r[31:12], rd, 7'h37};
      8:       return {r[31:12], rd, 7'h17};
      default: return {r[31:7], 7'h7F};
    endcase
  endfunction

  logic [31:0] i_add6, i_lw3, i_add4, i_addi7, i_addi9, i_beq, i_bltu;

  initial begin
    i_add6  = {7'd0, 5'd0, 5'd5, 3'd0, 5'd6, 7'h33};
    i_lw3   = {12'd0, 5'd1, 3'b010, 5'd3, 7'h03};
    i_add4  = {7'd0, 5'd2, 5'd3, 3'd0, 5'd4, 7'h33};
    i_addi7 = {12'd5, 5'd0, 3'd0, 5'd7, 7'h13};
    i_addi9 = {12'd1, 5'd0, 3'd0, 5'd9, 7'h13};
    i_beq   = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1, 7'h63};
    i_bltu  = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b110, 4'b1100, 1'b1, 7'h63};

    // Reset held two cycles while an instruction is offered.
    rst = 1; in_valid = 1; instr = i_add6; pc_d = 32'h100; pc4_d = 32'h104;
    flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    model_reset();
    @(posedge clk); #1;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_e1", rd_e1, 0);
    chk("rst_rd_e2", rd_e2, 0);
    chk("rst_imm_e", imm_e, 0);
    chk("rst_pc_e", pc_e, 0);
    chk("rst_pc4_e", pc4_e, 0);
    chk("rst_rd_e", rd_e, 0);
    chk("rst_alu", alu_ctrl, 0);
    chk("rst_wb_sel", write_back_e, 0);
    chk("rst_reg_write", reg_write_e, 0);
    rst = 0;

    // Same-cycle WB write of x5 seen by the ID read.
    wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; in_valid = 1; instr = i_add6;
    step();
    chk("bypass_rd_e1", rd_e1, 32'hDEADBEEF);
    chk("bypass_valid", out_valid, 1);
    wb_en = 0;

    // Load-use: lw x3 then add x4,x3,x2.
    instr = i_lw3; pc_d = 32'h200; pc4_d = 32'h204;
    step();
    instr = i_add4; pc_d = 32'h204; pc4_d = 32'h208;
    #1 chk("lu_in_ready_stall", in_ready, 0);
    step();
    chk("lu_bubble", out_valid, 0);
    #1 chk("lu_in_ready_resume", in_ready, 1);
    step();
    chk("lu_add_valid", out_valid, 1);
    chk("lu_add_rd", rd_e, 4);

    // Back-pressure for three cycles, then release.
    out_ready = 0; instr = i_addi7; pc_d = 32'h208; pc4_d = 32'h20C;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      step();
      chk("bp_hold_rd", rd_e, 4);
      chk("bp_hold_pc", pc_e, 32'h204);
    end
    out_ready = 1;
    #1 chk("bp_release_ready", in_ready, 1);
    step();
    chk("bp_next_rd", rd_e, 7);
    chk("bp_next_imm", imm_e, 5);

    // Flush with an offered instruction.
    flush = 1; instr = i_addi9;
    #1 chk("fl_in_ready", in_ready, 1);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_reg_write", reg_write_e, 0);
    flush = 0; in_valid = 0;
    step();
    chk("fl_never", out_valid, 0);

    // Branch compare: x1 = x2 = 7.
    wb_en = 1; wb_addr = 1; wb_data = 7;
    step();
    wb_addr = 2;
    step();
    wb_en = 0; in_valid = 1; instr = i_beq; pc_d = 32'h300; pc4_d = 32'h304;
    step();
    chk("beq_taken", branch_result_e, 1);
    chk("beq_imm", imm_e, 32'hFFFFFFF8);
    instr = i_bltu;
    step();
    chk("bltu_not_taken", branch_result_e, 0);
    chk("bltu_imm", imm_e, 32'hFFFFFFF8);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 11) == 0);
      wb_en     = $urandom_range(0, 1);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      instr     = rand_instr();
      pc_d      = $urandom & 32'hFFFFFFFC;
      pc4_d     = pc_d + 4;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
